// File: rtl/sprite_scheduler.sv
// sprite_scheduler: snapshots the live sprite table on each frame boundary and issues active entries to the blitter
module sprite_scheduler #(
   parameter int MAX_SPRITES   = 16,
   parameter int CANVAS_WIDTH  = 360,
   parameter int CANVAS_HEIGHT = 720,
   parameter int NUM_FRAMES    = 18,
   parameter int ACK_TIMEOUT   = 8,
   localparam int IW = $clog2(MAX_SPRITES),
   localparam int XW = $clog2(CANVAS_WIDTH),
   localparam int YW = $clog2(CANVAS_HEIGHT),
   localparam int FW = $clog2(NUM_FRAMES)
) (
   input  logic          clk_pixel,
   input  logic          sys_rst,
   input  logic [5:0]    frame_count,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_index,
   input  logic          wr_active,
   input  logic [XW-1:0] wr_x,
   input  logic [YW-1:0] wr_y,
   input  logic [FW-1:0] wr_frame,
   input  logic          sprite_ready,
   output logic          sprite_valid,
   output logic [XW-1:0] sprite_x,
   output logic [YW-1:0] sprite_y,
   output logic [FW-1:0] sprite_frame_number,
   output logic          busy,
   output logic          frame_done,
   output logic          overrun,
   output logic          ack_error,
   output logic [IW:0]   issued_count
);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, SCAN, WAIT_ACK, WAIT_DONE} state_t;
   state_t        state;
   logic [5:0]    prev_fc;
   logic          live_act [MAX_SPRITES];
   logic [XW-1:0] live_x   [MAX_SPRITES];
   logic [YW-1:0] live_y   [MAX_SPRITES];
   logic [FW-1:0] live_f   [MAX_SPRITES];
   logic          sh_act   [MAX_SPRITES];
   logic [XW-1:0] sh_x     [MAX_SPRITES];
   logic [YW-1:0] sh_y     [MAX_SPRITES];
   logic [FW-1:0] sh_f     [MAX_SPRITES];
   logic [IW-1:0] idx;
   logic [TW-1:0] ack_cnt;
   logic          restart_pending;
   logic          fedge, last, ent_ok, timeout, done_ent, snap;

   assign fedge    = frame_count != prev_fc;
   assign last     = 32'(idx) == MAX_SPRITES - 1;
   assign ent_ok   = sh_act[idx] && 32'(sh_f[idx]) < NUM_FRAMES;
   assign timeout  = 32'(ack_cnt) == ACK_TIMEOUT - 1;
   assign busy     = state != IDLE;
   // an entry is finished when the blitter returns to idle or never acknowledged within the timeout
   assign done_ent = sprite_ready && ((state == WAIT_ACK && timeout) || state == WAIT_DONE);
   // a restart happens at once when nothing is in flight, otherwise when the in-flight sprite finishes
   assign snap     = (fedge && (state == IDLE || state == SCAN)) ||
                     (done_ent && (restart_pending || fedge));

   // live table written by game logic; only the enables need clearing on reset
   always_ff @(posedge clk_pixel)
      if (sys_rst)
         for (int i = 0; i < MAX_SPRITES; i++) live_act[i] <= 1'b0;
      else if (wr_en && 32'(wr_index) < MAX_SPRITES) begin
         live_act[wr_index] <= wr_active;
         live_x[wr_index]   <= wr_x;
         live_y[wr_index]   <= wr_y;
         live_f[wr_index]   <= wr_frame;
      end

   // shadow copy taken at a restart; a write on the same edge is not yet visible here
   always_ff @(posedge clk_pixel)
      if (snap)
         for (int i = 0; i < MAX_SPRITES; i++) begin
            sh_act[i] <= live_act[i];
            sh_x[i]   <= live_x[i];
            sh_y[i]   <= live_y[i];
            sh_f[i]   <= live_f[i];
         end

   // issue sequencer: scan the shadow table, hand one sprite at a time to the blitter
   always_ff @(posedge clk_pixel) begin
      prev_fc <= frame_count;
      if (sys_rst) begin
         state               <= IDLE;
         idx                 <= '0;
         ack_cnt             <= '0;
         restart_pending     <= 1'b0;
         sprite_valid        <= 1'b0;
         sprite_x            <= '0;
         sprite_y            <= '0;
         sprite_frame_number <= '0;
         frame_done          <= 1'b0;
         overrun             <= 1'b0;
         ack_error           <= 1'b0;
         issued_count        <= '0;
      end else begin
         sprite_valid <= 1'b0;
         frame_done   <= 1'b0;
         if (fedge && busy) overrun <= 1'b1;
         if (done_ent && state == WAIT_ACK) ack_error <= 1'b1;
         if (snap) begin
            state           <= SCAN;
            idx             <= '0;
            issued_count    <= '0;
            restart_pending <= 1'b0;
         end else
            case (state)
               IDLE: ;
               SCAN:
                  if (ent_ok) begin
                     sprite_x            <= sh_x[idx];
                     sprite_y            <= sh_y[idx];
                     sprite_frame_number <= sh_f[idx];
                     sprite_valid        <= 1'b1;
                     issued_count        <= issued_count + 1'b1;
                     ack_cnt             <= '0;
                     state               <= WAIT_ACK;
                  end else if (last) begin
                     frame_done <= 1'b1;
                     state      <= IDLE;
                  end else
                     idx <= idx + 1'b1;
               WAIT_ACK, WAIT_DONE: begin
                  if (fedge) restart_pending <= 1'b1;
                  if (done_ent) begin
                     frame_done <= last;
                     state      <= last ? IDLE : SCAN;
                     idx        <= last ? idx : idx + 1'b1;
                  end else if (state == WAIT_ACK) begin
                     if (!sprite_ready) state <= WAIT_DONE;
                     else ack_cnt <= ack_cnt + 1'b1;
                  end
               end
            endcase
      end
   end
endmodule
